// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display driver.
package seg_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_t;

  localparam int unsigned SEG_W = 7;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Clock cycles per digit slot for the requested frame refresh rate
  function automatic int unsigned digit_cycles(input int unsigned clk_per_ns,
                                               input int unsigned refr_hz,
                                               input int unsigned num_digits);
    return 32'(64'd1_000_000_000 /
               (64'(clk_per_ns) * 64'(refr_hz) * 64'(num_digits)));
  endfunction

endpackage

// File: rtl/seven_segment_mux_if.sv
// Host-side data/control and display-side drive signals of the display driver.
interface seven_segment_mux_if #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned PWM_BITS   = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [PWM_BITS-1:0]     brightness;
  logic                    load;
  logic                    update_pending;
  logic                    frame_tick;
  logic [NUM_DIGITS-1:0]   anode;
  logic [7:0]              cathode;

  modport master (
    output value_in, dp_in, digit_en, lz_blank, brightness, load,
    input  update_pending, frame_tick, anode, cathode
  );

  modport slave (
    input  value_in, dp_in, digit_en, lz_blank, brightness, load,
    output update_pending, frame_tick, anode, cathode
  );
endinterface

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed seven-segment driver with per-slot dead time, PWM dimming,
// leading-zero blanking and frame-synchronous shadow update.
module seven_segment_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned CLK_PER      = 10,
  parameter int unsigned REFR_RATE    = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned PWM_BITS     = 4
) (
  input  logic              clk,
  input  logic              reset,
  seven_segment_mux_if.slave bus
);

  localparam int unsigned DIGIT_CYCLES = digit_cycles(CLK_PER, REFR_RATE, NUM_DIGITS);
  localparam int unsigned ON_CYCLES    = DIGIT_CYCLES - BLANK_CYCLES;
  localparam int unsigned CNT_W        = $clog2(DIGIT_CYCLES);
  localparam int unsigned IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W        = 4 * NUM_DIGITS;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16 || BLANK_CYCLES == 0 ||
      DIGIT_CYCLES <= BLANK_CYCLES) begin : g_bad_cfg
    $error("seven_segment_mux: slot too short for dead time or bad digit count");
  end

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [CNT_W-1:0]       cnt;
  logic [PWM_BITS-1:0]    pwm_cnt;
  logic [VAL_W-1:0]       val_sh, val_st;
  logic [NUM_DIGITS-1:0]  dp_sh, dp_st, en_sh, en_st;
  logic                   update_pending;
  logic                   frame_tick;
  logic [NUM_DIGITS-1:0]  anode;
  logic [7:0]             cathode;

  logic [NUM_DIGITS-1:0]  vis_c;
  logic [3:0]             cur_nib_c;
  logic [SEG_W-1:0]       cur_seg_c;
  logic                   cur_vis_c;
  logic                   pwm_on_c;
  logic                   frame_start_c;
  logic [IDX_W-1:0]       idx_next_c;

  // A digit is hidden when disabled, or when it and everything above it is zero
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    vis_c      = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (val_sh[4*k +: 4] == 4'h0);
      vis_c[k]   = en_sh[k] && !(bus.lz_blank && zero_above && (k != 0));
    end
  end

  assign cur_nib_c     = val_sh[{idx, 2'b00} +: 4];
  assign cur_vis_c     = vis_c[idx];
  assign pwm_on_c      = (bus.brightness == '1) || (pwm_cnt < bus.brightness);
  assign frame_start_c = (state == S_BLANK) && (cnt == '0) && (idx == '0);
  assign idx_next_c    = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

  seg_decode u_decode (
    .nibble (cur_nib_c),
    .seg_c  (cur_seg_c)
  );

  // Slot sequencer, shadow update and registered display drive
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      cnt            <= '0;
      pwm_cnt        <= '0;
      val_sh         <= '0;
      val_st         <= '0;
      dp_sh          <= '0;
      dp_st          <= '0;
      en_sh          <= '0;
      en_st          <= '0;
      update_pending <= 1'b0;
      frame_tick     <= 1'b0;
      anode          <= '1;
      cathode        <= '1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      unique case (state)
        S_IDLE: begin
          state <= S_BLANK;
          cnt   <= '0;
        end
        S_BLANK: begin
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            state   <= S_ON;
            cnt     <= '0;
            pwm_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ON: begin
          if (cnt == CNT_W'(ON_CYCLES - 1)) begin
            state <= S_BLANK;
            cnt   <= '0;
            idx   <= idx_next_c;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Outputs trail the sequencer state by one cycle
      frame_tick <= frame_start_c;
      if (state == S_ON) begin
        anode   <= ~(NUM_DIGITS'(cur_vis_c && pwm_on_c) << idx);
        cathode <= {~(dp_sh[idx] && cur_vis_c), cur_seg_c};
      end else begin
        anode   <= '1;
        cathode <= '1;
      end

      if (frame_start_c && update_pending) begin
        val_sh <= val_st;
        dp_sh  <= dp_st;
        en_sh  <= en_st;
      end

      // A load on the capture edge is held over to the following frame
      if (bus.load) begin
        val_st         <= bus.value_in;
        dp_st          <= bus.dp_in;
        en_st          <= bus.digit_en;
        update_pending <= 1'b1;
      end else if (frame_start_c) begin
        update_pending <= 1'b0;
      end
    end
  end

  assign bus.anode          = anode;
  assign bus.cathode        = cathode;
  assign bus.frame_tick     = frame_tick;
  assign bus.update_pending = update_pending;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux with a frame-position reference model.
module tb_seven_segment_mux;

  localparam int ND = 4;
  localparam int B  = 4;
  localparam int D  = 25;
  localparam int FR = ND * D;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  seven_segment_mux_if #(.NUM_DIGITS(ND), .PWM_BITS(4)) bus ();

  seven_segment_mux #(
    .NUM_DIGITS   (ND),
    .CLK_PER      (10),
    .REFR_RATE    (1_000_000),
    .BLANK_CYCLES (B),
    .PWM_BITS     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: output position in the frame is a pure function of cycles since reset
  logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit          model_ok = 1'b0;
  int          n_edges;
  logic [15:0] m_val_sh, m_val_st;
  logic [3:0]  m_dp_sh, m_dp_st, m_en_sh, m_en_st;
  logic        m_pending;
  logic [3:0]  e_anode;
  logic [7:0]  e_cathode;
  logic        e_ft, e_pend;

  always @(posedge clk) begin : model
    int f, d, s, pwm;
    logic [3:0] nib;
    logic vis, lit;
    if (!reset) begin
      n_edges = 0;
      m_val_sh = '0; m_val_st = '0;
      m_dp_sh = '0;  m_dp_st = '0;
      m_en_sh = '0;  m_en_st = '0;
      m_pending = 1'b0;
      e_anode = 4'hF; e_cathode = 8'hFF; e_ft = 1'b0; e_pend = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      n_edges++;
      e_anode = 4'hF; e_cathode = 8'hFF; e_ft = 1'b0;
      if (n_edges >= 2) begin
        f = (n_edges - 2) % FR;
        d = f / D;
        s = f % D;
        e_ft = (f == 0);
        if (s >= B) begin
          nib = 4'(m_val_sh >> (4 * d));
          vis = m_en_sh[d] && !(bus.lz_blank && d > 0 && (m_val_sh >> (4 * d)) == 16'd0);
          pwm = (s - B) % 16;
          lit = vis && (bus.brightness == 4'hF || pwm < int'(bus.brightness));
          e_anode[d] = ~lit;
          e_cathode = {~(m_dp_sh[d] & vis), ~glyph[nib]};
        end
        if (e_ft && m_pending) begin
          m_val_sh = m_val_st; m_dp_sh = m_dp_st; m_en_sh = m_en_st;
        end
      end
      if (bus.load) begin
        m_val_st = bus.value_in; m_dp_st = bus.dp_in; m_en_st = bus.digit_en;
        m_pending = 1'b1;
      end else if (e_ft) begin
        m_pending = 1'b0;
      end
      e_pend = m_pending;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("anode",          bus.anode,          e_anode);
      chk("cathode",        bus.cathode,        e_cathode);
      chk("frame_tick",     bus.frame_tick,     e_ft);
      chk("update_pending", bus.update_pending, e_pend);
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_ft();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) break;
    end
    chk("frame_tick_wait", bus.frame_tick, 1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
    bus.value_in = v;
    bus.dp_in    = dp;
    bus.digit_en = en;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic count_frame(input string name, input int expn);
    int n = 0;
    for (int i = 0; i < FR; i++) begin
      n += ND - $countones(bus.anode);
      @(negedge clk);
    end
    chk(name, n, expn);
  endtask

  initial begin
    bus.value_in   = '0;
    bus.dp_in      = '0;
    bus.digit_en   = '0;
    bus.lz_blank   = 1'b0;
    bus.brightness = 4'hF;
    bus.load       = 1'b0;

    tick(3);
    chk("reset_anode",   bus.anode,   4'hF);
    chk("reset_cathode", bus.cathode, 8'hFF);
    reset = 1'b1;
    tick(1);
    chk("ft_release_1", bus.frame_tick, 0);
    tick(1);
    chk("ft_release_2", bus.frame_tick, 1);

    // Load on the frame_tick cycle: applied one frame later
    do_load(16'h1234, 4'b0100, 4'hF);
    chk("pending_set", bus.update_pending, 1);
    tick(3);
    chk("old_frame_dark", bus.anode, 4'hF);
    wait_ft();
    chk("pending_clear", bus.update_pending, 0);
    tick(4);
    chk("d0_anode", bus.anode, 4'b1110);
    chk("d0_cath",  bus.cathode, 8'h99);
    tick(20);
    chk("d0_last_on", bus.anode, 4'b1110);
    tick(1);
    chk("d1_blank", bus.anode, 4'hF);
    tick(4);
    chk("d1_anode", bus.anode, 4'b1101);
    tick(25);
    chk("d2_anode", bus.anode, 4'b1011);
    chk("d2_cath_dp", bus.cathode, 8'h24);
    tick(25);
    chk("d3_anode", bus.anode, 4'b0111);
    chk("d3_cath",  bus.cathode, 8'hF9);

    // Brightness is live
    wait_ft();
    count_frame("lit_full", 84);
    bus.brightness = 4'h4;
    count_frame("lit_b4", 32);
    bus.brightness = 4'h0;
    count_frame("lit_b0", 0);
    bus.brightness = 4'hF;

    // Leading-zero blanking
    tick(10);
    do_load(16'h0070, 4'h0, 4'hF);
    bus.lz_blank = 1'b1;
    wait_ft();
    tick(4);
    chk("lz_d0_anode", bus.anode, 4'b1110);
    chk("lz_d0_cath",  bus.cathode, 8'hC0);
    tick(25);
    chk("lz_d1_anode", bus.anode, 4'b1101);
    chk("lz_d1_cath",  bus.cathode, 8'hF8);
    tick(25);
    chk("lz_d2_dark", bus.anode, 4'hF);
    tick(25);
    chk("lz_d3_dark", bus.anode, 4'hF);
    wait_ft();
    bus.lz_blank = 1'b0;
    count_frame("lz_off_lit", 84);

    // Mid-frame load keeps the old digits until the next frame
    tick(55);
    do_load(16'hAAAA, 4'h0, 4'hF);
    chk("mid_pending", bus.update_pending, 1);
    tick(4);
    chk("mid_d2_anode", bus.anode, 4'b1011);
    chk("mid_d2_old",   bus.cathode, 8'hC0);
    tick(19);
    chk("mid_d3_old", bus.cathode, 8'hC0);
    wait_ft();
    chk("mid_pending_clr", bus.update_pending, 0);
    tick(4);
    chk("new_d0_anode", bus.anode, 4'b1110);
    chk("new_d0_cath",  bus.cathode, 8'h88);

    // Repeated loads: the latest wins; disabled digit hides its dp too
    tick(6);
    do_load(16'h5555, 4'h0, 4'hF);
    tick(20);
    do_load(16'h1239, 4'b0001, 4'b1110);
    wait_ft();
    tick(4);
    chk("dis_d0_anode", bus.anode, 4'hF);
    chk("dis_d0_cath",  bus.cathode, 8'h90);
    tick(25);
    chk("rep_d1_anode", bus.anode, 4'b1101);
    chk("rep_d1_cath",  bus.cathode, 8'hB0);

    // One-cycle reset inside digit 1's lit slot
    do_load(16'hFFFF, 4'hF, 4'hF);
    tick(5);
    reset = 1'b0;
    tick(1);
    chk("rst_anode",   bus.anode,   4'hF);
    chk("rst_cathode", bus.cathode, 8'hFF);
    chk("rst_pending", bus.update_pending, 0);
    chk("rst_ft",      bus.frame_tick, 0);
    reset = 1'b1;
    tick(1);
    chk("rst_ft_1", bus.frame_tick, 0);
    tick(1);
    chk("rst_ft_2", bus.frame_tick, 1);
    tick(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
